// File: rtl/g2_pkg.sv
// Shared types and helpers for the g2 delay-histogram accumulator.
package g2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR,
        READ
    } g2_state_e;

    localparam int unsigned DAT_W_DEF  = 18;
    localparam int unsigned ADDR_W_DEF = 10;

    // Unsigned add clamped to the largest value representable in 'width' bits.
    function automatic logic [31:0] sat_add(input logic [31:0] base,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, base} + {1'b0, inc};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/g2_hist_accum_if.sv
// Event input and readout stream of the g2 histogram accumulator.
interface g2_hist_accum_if #(
    parameter int unsigned DAT_W     = 18,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned NUM_LANES = 32,
    parameter int unsigned INC_W     = 4
);
    logic [NUM_LANES-1:0]             in_valid;
    logic [NUM_LANES-1:0][ADDR_W-1:0] in_bin;
    logic [NUM_LANES-1:0][INC_W-1:0]  in_inc;
    logic                             in_ready;
    logic                             out_valid;
    logic                             out_ready;
    logic [ADDR_W-1:0]                out_bin;
    logic [NUM_LANES-1:0][DAT_W-1:0]  out_data;

    modport master (
        output in_valid, in_bin, in_inc, out_ready,
        input  in_ready, out_valid, out_bin, out_data
    );

    modport slave (
        input  in_valid, in_bin, in_inc, out_ready,
        output in_ready, out_valid, out_bin, out_data
    );
endinterface

// File: rtl/g2_rmw_lane.sv
// One lane's read-modify-write pipeline: S0 issues the read, S1 adds and writes back.
module g2_rmw_lane import g2_pkg::*; #(
    parameter int unsigned DAT_W  = DAT_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_valid,
    input  logic [ADDR_W-1:0] ev_bin,
    input  logic [INC_W-1:0]  ev_inc,
    input  logic [DAT_W-1:0]  ram_rd,
    output logic [ADDR_W-1:0] ram_ra,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wa,
    output logic [DAT_W-1:0]  ram_wd
);
    logic              s0_v;
    logic [ADDR_W-1:0] s0_bin;
    logic [INC_W-1:0]  s0_inc;
    logic              s1_v;
    logic [ADDR_W-1:0] s1_bin;
    logic [INC_W-1:0]  s1_inc;
    logic              s1_fwd;
    logic [DAT_W-1:0]  fwd_sum;
    logic [DAT_W-1:0]  base;
    logic [DAT_W-1:0]  sum;

    // A back-to-back hit on the same bin read stale RAM data; use the captured sum instead.
    always_comb begin
        base = s1_fwd ? fwd_sum : ram_rd;
        sum  = DAT_W'(sat_add(32'(base), 32'(s1_inc), DAT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v    <= 1'b0;
            s0_bin  <= '0;
            s0_inc  <= '0;
            s1_v    <= 1'b0;
            s1_bin  <= '0;
            s1_inc  <= '0;
            s1_fwd  <= 1'b0;
            fwd_sum <= '0;
        end else begin
            s0_v <= ev_valid;
            if (ev_valid) begin
                s0_bin <= ev_bin;
                s0_inc <= ev_inc;
            end
            s1_v    <= s0_v;
            s1_bin  <= s0_bin;
            s1_inc  <= s0_inc;
            s1_fwd  <= s0_v & s1_v & (s0_bin == s1_bin);
            fwd_sum <= sum;
        end
    end

    assign ram_ra = s0_bin;
    assign ram_we = s1_v;
    assign ram_wa = s1_bin;
    assign ram_wd = sum;
endmodule

// File: rtl/g2_hist_accum.sv
// Histogram bank controller: per-lane accumulation, whole-bank clear and streamed readout.
module g2_hist_accum import g2_pkg::*; #(
    parameter int unsigned DAT_W     = DAT_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned NUM_LANES = 32,
    parameter int unsigned INC_W     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    g2_hist_accum_if.slave                   bus,
    input  logic                             clear_start,
    input  logic                             rd_start,
    input  logic                             rd_clear,
    output logic                             busy,
    output logic                             hist_clean,
    output logic [NUM_LANES-1:0]             ram_we,
    output logic [NUM_LANES-1:0][ADDR_W-1:0] ram_wa,
    output logic [NUM_LANES-1:0][ADDR_W-1:0] ram_ra,
    output logic [NUM_LANES-1:0][DAT_W-1:0]  ram_wd,
    input  logic [NUM_LANES-1:0][DAT_W-1:0]  ram_rd
);
    localparam logic [ADDR_W-1:0] LAST_BIN = '1;

    g2_state_e                        state_q, state_d;
    logic                             drain_cnt_q;
    logic                             mode_clr_q;
    logic                             rd_clr_q;
    logic [ADDR_W-1:0]                addr_q;
    logic                             issue_done_q;
    logic                             rd_pend_q;
    logic [ADDR_W-1:0]                pend_bin_q;
    logic                             hold_v_q;
    logic [ADDR_W-1:0]                hold_bin_q;
    logic [NUM_LANES-1:0][DAT_W-1:0]  hold_data_q;
    logic                             clean_q;

    logic                             acc_en;
    logic                             clr_we;
    logic                             rd_issue;
    logic                             hold_free;

    logic [NUM_LANES-1:0]             lane_we;
    logic [NUM_LANES-1:0][ADDR_W-1:0] lane_wa;
    logic [NUM_LANES-1:0][ADDR_W-1:0] lane_ra;
    logic [NUM_LANES-1:0][DAT_W-1:0]  lane_wd;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        g2_rmw_lane #(
            .DAT_W  (DAT_W),
            .ADDR_W (ADDR_W),
            .INC_W  (INC_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .ev_valid (bus.in_valid[i] & acc_en),
            .ev_bin   (bus.in_bin[i]),
            .ev_inc   (bus.in_inc[i]),
            .ram_rd   (ram_rd[i]),
            .ram_ra   (lane_ra[i]),
            .ram_we   (lane_we[i]),
            .ram_wa   (lane_wa[i]),
            .ram_wd   (lane_wd[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // One read in flight at most, so a returning word always finds the holding reg free.
    always_comb begin
        state_d   = state_q;
        acc_en    = 1'b0;
        clr_we    = 1'b0;
        rd_issue  = 1'b0;
        hold_free = ~hold_v_q | bus.out_ready;
        case (state_q)
            IDLE: begin
                acc_en = 1'b1;
                if (clear_start || rd_start) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt_q) state_d = mode_clr_q ? CLEAR : READ;
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (addr_q == LAST_BIN) state_d = IDLE;
            end
            READ: begin
                rd_issue = ~rd_pend_q & ~issue_done_q & hold_free;
                if (hold_v_q && bus.out_ready && hold_bin_q == LAST_BIN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_q  <= 1'b0;
            mode_clr_q   <= 1'b0;
            rd_clr_q     <= 1'b0;
            addr_q       <= '0;
            issue_done_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            pend_bin_q   <= '0;
            hold_v_q     <= 1'b0;
            hold_bin_q   <= '0;
            hold_data_q  <= '0;
            clean_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == DRAIN) begin
                mode_clr_q <= clear_start;
                rd_clr_q   <= rd_clear & ~clear_start;
            end
            drain_cnt_q <= (state_q == DRAIN) ? ~drain_cnt_q : 1'b0;
            if (clr_we || rd_issue) addr_q <= addr_q + ADDR_W'(1);
            if (state_q == IDLE) issue_done_q <= 1'b0;
            else if (rd_issue && addr_q == LAST_BIN) issue_done_q <= 1'b1;
            rd_pend_q <= rd_issue;
            if (rd_issue) pend_bin_q <= addr_q;
            if (rd_pend_q) begin
                hold_v_q    <= 1'b1;
                hold_bin_q  <= pend_bin_q;
                hold_data_q <= ram_rd;
            end else if (hold_v_q && bus.out_ready) begin
                hold_v_q <= 1'b0;
            end
            if (state_q == CLEAR && state_d == IDLE) clean_q <= 1'b1;
            else if (state_q == IDLE && |bus.in_valid) clean_q <= 1'b0;
        end
    end

    always_comb begin
        ram_we = lane_we;
        ram_wa = lane_wa;
        ram_wd = lane_wd;
        ram_ra = lane_ra;
        if (state_q == CLEAR) begin
            ram_we = '1;
            ram_wd = '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) ram_wa[i] = addr_q;
        end else if (state_q == READ) begin
            ram_we = {NUM_LANES{rd_pend_q & rd_clr_q}};
            ram_wd = '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                ram_wa[i] = pend_bin_q;
                ram_ra[i] = addr_q;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = hold_v_q;
    assign bus.out_bin   = hold_bin_q;
    assign bus.out_data  = hold_data_q;
    assign busy          = (state_q != IDLE);
    assign hist_clean    = clean_q;
endmodule
